// File: rtl/controle_tentativas.sv
// -----------------------------------------------------------------------------
// controle_tentativas
//
// Sequential front end of the safe. A press of the confirm button captures the
// 4-bit guess on the switches into `tentativa`, which feeds the external
// subtractor/comparator. One clock later the comparator's `igual` result is
// consumed. Consecutive wrong guesses are counted. After MAX_TENT failures the
// safe locks for LOCK_CYCLES clocks.
//
// Parameters
//   MAX_TENT         wrong guesses before lockout (1..7)
//   LOCK_CYCLES      clocks spent in lockout (>= 1)
//   DEBOUNCE_CYCLES  stable clocks needed on confirma (debounce build only)
//
// Optional feature
//   CONFIRMA_DEBOUNCE_EN  when defined, a debounce counter sits between the
//                         synchronizer and the edge detector. conf_p then
//                         asserts 3+DEBOUNCE_CYCLES clocks after a clean rise,
//                         and shorter pulses are discarded.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   chaves     in   4  guess from the switches (asynchronous, read on a press)
//   confirma   in   1  raw confirm button, active-high, asynchronous
//   igual      in   1  comparator result: senha == tentativa
//   tentativa  out  4  registered guess, drives subtractor input B
//   avaliar    out  1  1-clock strobe: igual is valid for current tentativa
//   aberto     out  1  safe open
//   bloqueado  out  1  lockout active
//   erros      out  3  consecutive wrong guesses so far, 0..MAX_TENT-1
//   estado     out  2  debug view of the FSM state register
//
// Handshake: avaliar is a one-clock strobe that is high while the FSM is in
// AVALIA. The comparator must present igual for the current tentativa during
// that clock, and igual is sampled at the end of that clock. igual is ignored
// in every other clock. No back-pressure exists.
// -----------------------------------------------------------------------------
module controle_tentativas #(
    parameter int MAX_TENT        = 3,
    parameter int LOCK_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] chaves,
    input  logic       confirma,
    input  logic       igual,
    output logic [3:0] tentativa,
    output logic       avaliar,
    output logic       aberto,
    output logic       bloqueado,
    output logic [2:0] erros,
    output logic [1:0] estado
);

    localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_INI  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]        MAX_TENT4 = 4'(MAX_TENT);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        AVALIA    = 2'd1,
        ABERTO    = 2'd2,
        BLOQUEADO = 2'd3
    } estado_t;

    estado_t           st;
    logic [LOCK_W-1:0] lock_cnt;

    // -------------------------------------------------------------------------
    // Input path: 2-FF synchronizer, optional debounce, rising-edge detector
    // -------------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic nivel;    // clean button level seen by the edge detector
    logic nivel_q;
    logic conf_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= confirma;
            sync2 <= sync1;
        end
    end

`ifdef CONFIRMA_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            deb;
    logic [DB_W-1:0] db_cnt;

    // The debounced level follows sync2 only after sync2 has disagreed with it
    // for DEBOUNCE_CYCLES consecutive clocks. Any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb    <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 != deb) begin
            if (db_cnt == DB_LAST) begin
                deb    <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign nivel = deb;
`else
    // Without the debounce counter, the synchronized level feeds the edge
    // detector directly. DEBOUNCE_CYCLES has no effect in this build.
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
    assign nivel               = sync2;
`endif

    // conf_p is registered, so a press reaches the FSM 3 clocks after
    // confirma rises (plus the debounce time when debounce is enabled).
    always_ff @(posedge clk) begin
        if (rst) begin
            nivel_q <= 1'b0;
            conf_p  <= 1'b0;
        end else begin
            nivel_q <= nivel;
            conf_p  <= nivel & ~nivel_q;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM. Outputs are registered and are updated in the same
    // assignment as the state, so they always match the state register.
    // -------------------------------------------------------------------------
    logic [3:0] erros_inc;
    assign erros_inc = {1'b0, erros} + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= OCIOSO;
            tentativa <= 4'd0;
            erros     <= 3'd0;
            lock_cnt  <= '0;
            avaliar   <= 1'b0;
            aberto    <= 1'b0;
            bloqueado <= 1'b0;
        end else begin
            case (st)
                OCIOSO: begin
                    // The only place tentativa is written.
                    if (conf_p) begin
                        tentativa <= chaves;
                        st        <= AVALIA;
                        avaliar   <= 1'b1;
                    end
                end

                AVALIA: begin
                    // Lasts one clock. conf_p is ignored here.
                    avaliar <= 1'b0;
                    if (igual) begin
                        erros  <= 3'd0;
                        st     <= ABERTO;
                        aberto <= 1'b1;
                    end else if (erros_inc < MAX_TENT4) begin
                        erros <= erros_inc[2:0];
                        st    <= OCIOSO;
                    end else begin
                        // Last allowed failure: clear erros and start the lockout.
                        erros     <= 3'd0;
                        lock_cnt  <= LOCK_INI;
                        st        <= BLOQUEADO;
                        bloqueado <= 1'b1;
                    end
                end

                ABERTO: begin
                    // A press closes the safe. The switches are ignored.
                    if (conf_p) begin
                        st     <= OCIOSO;
                        aberto <= 1'b0;
                    end
                end

                BLOQUEADO: begin
                    // lock_cnt is loaded with LOCK_CYCLES-1 on entry, so the
                    // terminal count at 0 gives exactly LOCK_CYCLES clocks here.
                    if (lock_cnt == '0) begin
                        st        <= OCIOSO;
                        bloqueado <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt - LOCK_W'(1);
                    end
                end

                default: begin
                    st        <= OCIOSO;
                    avaliar   <= 1'b0;
                    aberto    <= 1'b0;
                    bloqueado <= 1'b0;
                end
            endcase
        end
    end

    assign estado = st;

endmodule
